// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout and bubble encoding.
package pipe_pkg;

  localparam int unsigned CTRL_W      = 12;
  localparam int unsigned MEMREAD_BIT = 3;

  // Control-bundle bit positions
  localparam int unsigned CtrlRegWrite = 0;
  localparam int unsigned CtrlMemToReg = 1;
  localparam int unsigned CtrlMemWrite = 2;
  localparam int unsigned CtrlMemRead  = MEMREAD_BIT;
  localparam int unsigned CtrlAluSrc   = 4;
  localparam int unsigned CtrlAluOpLsb = 5;
  localparam int unsigned CtrlAluOpW   = 4;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the consumer in ID.
module load_use_detect #(
  parameter int unsigned CTRL_W      = pipe_pkg::CTRL_W,
  parameter int unsigned MEMREAD_BIT = pipe_pkg::MEMREAD_BIT
) (
  input  logic              ex_valid_i,
  input  logic [CTRL_W-1:0] ex_ctrl_i,
  input  logic [4:0]        ex_rt_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

  // A load into $0 never produces a value worth waiting for.
  assign hazard_o = ex_valid_i && ex_ctrl_i[MEMREAD_BIT] && id_valid_i &&
                    (ex_rt_i != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold and flush.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = pipe_pkg::CTRL_W,
  parameter int unsigned MEMREAD_BIT = pipe_pkg::MEMREAD_BIT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm_ext;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_use_detect #(
    .CTRL_W      (CTRL_W),
    .MEMREAD_BIT (MEMREAD_BIT)
  ) u_load_use_detect (
    .ex_valid_i   (stage_q.valid),
    .ex_ctrl_i    (stage_q.ctrl),
    .ex_rt_i      (stage_q.rt),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .hazard_o     (load_use_hazard)
  );

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (load_use_hazard) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      stage_d.valid   = id_valid;
      stage_d.pc      = id_pc;
      stage_d.rs_data = id_rs_data;
      stage_d.rt_data = id_rt_data;
      stage_d.imm_ext = id_imm_ext;
      stage_d.rs      = id_rs;
      stage_d.rt      = id_rt;
      stage_d.rd      = id_rd;
      // Dead slots keep their data but must never carry live control.
      stage_d.ctrl    = id_valid ? id_ctrl : CTRL_W'(BUBBLE_CTRL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid   = stage_q.valid;
  assign ex_pc      = stage_q.pc;
  assign ex_rs_data = stage_q.rs_data;
  assign ex_rt_data = stage_q.rt_data;
  assign ex_imm_ext = stage_q.imm_ext;
  assign ex_rs      = stage_q.rs;
  assign ex_rt      = stage_q.rt;
  assign ex_rd      = stage_q.rd;
  assign ex_ctrl    = stage_q.ctrl;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: scoreboard of expected EX state plus a 4-bit-counter twin.
module tb_id_ex_reg;

  localparam logic [11:0] CtrlLw  = 12'h01B;  // reg_write, mem_to_reg, alu_src, mem_read
  localparam logic [11:0] CtrlAdd = 12'h021;  // reg_write, alu_op=1

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_uses_rt;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [11:0] id_ctrl;

  logic        ex_valid, load_use_hazard;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [11:0] ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_hazard;
  logic [31:0] s_pc, s_rs_data, s_rt_data, s_imm_ext;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [11:0] s_ctrl;
  logic [3:0]  s_cnt;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_uses_rt(id_uses_rt), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
  );

  id_ex_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_uses_rt(id_uses_rt), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm_ext(s_imm_ext),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_ctrl(s_ctrl),
    .load_use_hazard(s_hazard), .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [11:0] ctrl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t m;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic model_hz();
    return m.valid && m.ctrl[3] && id_valid && (m.rt != 5'd0) &&
           ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
  endfunction

  function automatic exp_t bubble(input exp_t s);
    exp_t b = s;
    b.valid = 1'b0; b.pc = '0; b.rsd = '0; b.rtd = '0; b.imm = '0;
    b.rs = '0; b.rt = '0; b.rd = '0; b.ctrl = '0;
    return b;
  endfunction

  // Inputs must already be driven; predicts the next EX state, then checks it after the edge.
  task automatic step();
    logic hz;
    exp_t e;
    #1;
    hz = model_hz();
    chk("hazard", {31'd0, load_use_hazard}, {31'd0, hz});
    if (flush) begin
      m = bubble(m);
    end else if (stall) begin
      m = m;
    end else if (hz) begin
      m = bubble(m);
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      if (m.cnt4 != 4'hF) m.cnt4 = m.cnt4 + 4'd1;
    end else begin
      m.valid = id_valid; m.pc = id_pc; m.rsd = id_rs_data; m.rtd = id_rt_data;
      m.imm = id_imm_ext; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.ctrl = id_valid ? id_ctrl : 12'd0;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
    chk("ex_pc", ex_pc, e.pc);
    chk("ex_rs_data", ex_rs_data, e.rsd);
    chk("ex_rt_data", ex_rt_data, e.rtd);
    chk("ex_imm_ext", ex_imm_ext, e.imm);
    chk("ex_rs", {27'd0, ex_rs}, {27'd0, e.rs});
    chk("ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
    chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
    chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, e.ctrl});
    chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.cnt});
    chk("bubble_cnt4", {28'd0, s_cnt}, {28'd0, e.cnt4});
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic ur,
                       input logic [11:0] ctrl);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
    id_ctrl = ctrl; id_rs_data = pc ^ 32'hA5A5_0000; id_rt_data = ~pc;
    id_imm_ext = {pc[15:0], pc[31:16]};
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_imm"}, ex_imm_ext, 32'd0);
    chk({tag, "_data"}, ex_rs_data | ex_rt_data, 32'd0);
    chk({tag, "_regs"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    chk({tag, "_ctrl"}, {20'd0, ex_ctrl}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, bubble_cnt}, 32'd0);
    chk({tag, "_cnt4"}, {28'd0, s_cnt}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = bubble(m); m.cnt = '0; m.cnt4 = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0);
    #12;
    chk_zero("reset");
    rst = 1'b0;

    // Normal pass
    drive(1'b1, 32'h0040_0010, 5'd3, 5'd9, 5'd4, 1'b1, CtrlAdd);
    id_imm_ext = 32'hFFFF_8000;
    step();
    chk("pass_pc", ex_pc, 32'h0040_0010);
    chk("pass_imm", ex_imm_ext, 32'hFFFF_8000);
    chk("pass_rt", {27'd0, ex_rt}, 32'd9);
    chk("pass_valid", {31'd0, ex_valid}, 32'd1);

    // Dead slot: data captured, control forced off
    drive(1'b0, 32'h0040_0014, 5'd6, 5'd7, 5'd2, 1'b1, CtrlLw);
    step();

    // Async reset mid-cycle with a live instruction loaded
    drive(1'b1, 32'h0040_0018, 5'd1, 5'd2, 5'd3, 1'b1, CtrlAdd);
    step();
    drive(1'b1, 32'h0040_001C, 5'd4, 5'd5, 5'd6, 1'b1, CtrlAdd);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    #1 rst = 1'b0;
    m = bubble(m); m.cnt = '0; m.cnt4 = '0;

    // Load-use: lw $8 then add using $8
    drive(1'b1, 32'h0040_0020, 5'd29, 5'd8, 5'd0, 1'b0, CtrlLw);
    step();
    drive(1'b1, 32'h0040_0024, 5'd8, 5'd10, 5'd11, 1'b1, CtrlAdd);
    #1 chk("lu_hazard_on", {31'd0, load_use_hazard}, 32'd1);
    step();
    chk("lu_bubble_ctrl", {20'd0, ex_ctrl}, 32'd0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_hazard_off", {31'd0, load_use_hazard}, 32'd0);
    step();
    chk("lu_add_pc", ex_pc, 32'h0040_0024);

    // Load into $0 and unused rt never stall
    drive(1'b1, 32'h0040_0028, 5'd29, 5'd0, 5'd0, 1'b0, CtrlLw);
    step();
    drive(1'b1, 32'h0040_002C, 5'd29, 5'd5, 5'd0, 1'b0, CtrlLw);
    id_rs = 5'd0;
    #1 chk("zero_reg", {31'd0, load_use_hazard}, 32'd0);
    id_rs = 5'd29;
    step();
    drive(1'b1, 32'h0040_0030, 5'd1, 5'd5, 5'd12, 1'b0, CtrlAdd);
    #1 chk("rt_unused", {31'd0, load_use_hazard}, 32'd0);
    id_uses_rt = 1'b1;
    #1 chk("rt_used", {31'd0, load_use_hazard}, 32'd1);
    id_uses_rt = 1'b0;
    step();

    // Stall holds for three cycles while ID changes
    drive(1'b1, 32'h0040_0034, 5'd13, 5'd14, 5'd15, 1'b1, CtrlAdd);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0050_0000 + 32'(i * 4), 5'(16 + i), 5'(20 + i), 5'(24 + i), 1'b1,
            CtrlAdd);
      step();
      chk("stall_pc", ex_pc, 32'h0040_0034);
    end
    stall = 1'b0;
    drive(1'b1, 32'h0040_0038, 5'd17, 5'd18, 5'd19, 1'b1, CtrlAdd);
    step();
    chk("unstall_pc", ex_pc, 32'h0040_0038);

    // flush + stall + hazard: flush wins, no count
    drive(1'b1, 32'h0040_003C, 5'd1, 5'd7, 5'd0, 1'b0, CtrlLw);
    step();
    drive(1'b1, 32'h0040_0040, 5'd7, 5'd2, 5'd3, 1'b1, CtrlAdd);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("prio_valid", {31'd0, ex_valid}, 32'd0);
    chk("prio_cnt", {16'd0, bubble_cnt}, 32'd1);
    flush = 1'b0; stall = 1'b0;

    // 17 load-use bubbles: 4-bit counter saturates at 15
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h0060_0000 + 32'(i * 8), 5'd1, 5'd7, 5'd0, 1'b0, CtrlLw);
      step();
      drive(1'b1, 32'h0060_0004 + 32'(i * 8), 5'd7, 5'd2, 5'd3, 1'b1, CtrlAdd);
      step();
    end
    chk("sat_cnt4", {28'd0, s_cnt}, 32'd15);
    chk("sat_cnt16", {16'd0, bubble_cnt}, 32'd18);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
